// File: rtl/fp_addsub_arbiter_pkg.sv
// fp_addsub_arbiter_pkg: shared FP add/sub request type and requester source encoding
package fp_addsub_arbiter_pkg;

    // Operand bundle handed to the add/sub datapath (91 bits).
    typedef struct packed {
        logic        add_sub;
        logic        num1_sign;
        logic [7:0]  num1_exp;
        logic [46:0] num1_mant;
        logic [31:0] num2;
        logic        num1_is_nan;
        logic        num1_is_zero;
    } fp_add_req_t;

    typedef enum logic {
        SRC_ALU_E = 1'b0,
        SRC_FMA_E = 1'b1
    } fp_src_e;

    localparam logic SRC_FMA = 1'b1;
    localparam logic SRC_ALU = 1'b0;

endpackage

// File: rtl/fp_addsub_arbiter_if.sv
// fp_addsub_arbiter_if: requester, issue and completion signals of the FP add/sub arbiter
//   master: drives fma_*/alu_* requests, stall, flush; sees readies, issue_*, done_*, busy
//   slave : the arbiter side
interface fp_addsub_arbiter_if #(
    parameter int TAG_W = 5
);
    import fp_addsub_arbiter_pkg::*;

    logic             fma_valid;
    logic             fma_ready;
    fp_add_req_t      fma_req;
    logic [TAG_W-1:0] fma_tag;
    logic             alu_valid;
    logic             alu_ready;
    fp_add_req_t      alu_req;
    logic [TAG_W-1:0] alu_tag;
    logic             stall;
    logic             flush;
    logic             issue_valid;
    fp_add_req_t      issue_req;
    logic             done_valid;
    logic             done_src;
    logic [TAG_W-1:0] done_tag;
    logic             busy;

    modport master (
        output fma_valid, fma_req, fma_tag,
        output alu_valid, alu_req, alu_tag,
        output stall, flush,
        input  fma_ready, alu_ready,
        input  issue_valid, issue_req,
        input  done_valid, done_src, done_tag, busy
    );

    modport slave (
        input  fma_valid, fma_req, fma_tag,
        input  alu_valid, alu_req, alu_tag,
        input  stall, flush,
        output fma_ready, alu_ready,
        output issue_valid, issue_req,
        output done_valid, done_src, done_tag, busy
    );

endinterface

// File: rtl/fp_addsub_arbiter_tracker.sv
// fp_inflight_tracker: LAT-deep {valid, src, tag} shift register mirroring the add/sub pipeline
//   i_adv   : advance one stage (low while the datapath is stalled)
//   i_flush : drop every in-flight entry
//   i_valid/i_src/i_tag : entry entering the datapath this cycle
//   o_valid/o_src/o_tag : entry whose result leaves the datapath this cycle
//   o_any   : any entry in flight
module fp_inflight_tracker #(
    parameter int LAT   = 3,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_adv,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic             i_src,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    output logic             o_src,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_any
);

    logic [LAT-1:0]   r_valid;
    logic [LAT-1:0]   r_src;
    logic [TAG_W-1:0] r_tag [LAT];

    // Flush only clears valid bits; stale src/tag are masked by the cleared valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_src   <= '0;
            for (int k = 0; k < LAT; k++) r_tag[k] <= '0;
        end else if (i_flush) begin
            r_valid <= '0;
        end else if (i_adv) begin
            r_valid[0] <= i_valid;
            r_src[0]   <= i_src;
            r_tag[0]   <= i_tag;
            for (int k = 1; k < LAT; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_src[k]   <= r_src[k-1];
                r_tag[k]   <= r_tag[k-1];
            end
        end
    end

    assign o_valid = r_valid[LAT-1];
    assign o_src   = r_src[LAT-1];
    assign o_tag   = r_tag[LAT-1];
    assign o_any   = |r_valid;

endmodule

// File: rtl/fp_addsub_arbiter.sv
// fp_addsub_arbiter: shares one LAT-cycle FP add/sub datapath between the FMA and ALU requesters
//   clk, reset : clock and synchronous active-high reset
//   bus        : fp_addsub_arbiter_if.slave -- requests, stall/flush, issue drive, completion, busy
//   Optional FP_ARB_ROUND_ROBIN_EN: alternate grants on conflict; otherwise FMA has fixed priority.
module fp_addsub_arbiter
    import fp_addsub_arbiter_pkg::*;
#(
    parameter int LAT   = 3,
    parameter int TAG_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    fp_addsub_arbiter_if.slave    bus
);

    logic             w_ok;
    logic             w_grant_fma;
    logic             w_hs;
    logic             w_adv;
    logic             w_trk_any;
    logic             r_issue_valid;
    logic             r_issue_src;
    fp_add_req_t      r_issue_req;
    logic [TAG_W-1:0] r_issue_tag;

    // Grants are only offered when nothing blocks the pipe this edge.
    assign w_ok = !reset && !bus.stall && !bus.flush;

`ifdef FP_ARB_ROUND_ROBIN_EN
    logic r_ptr_fma;

    // On conflict the pointer picks; a lone valid requester always wins.
    assign w_grant_fma = !bus.alu_valid || (bus.fma_valid && r_ptr_fma);

    always_ff @(posedge clk) begin
        if (reset) r_ptr_fma <= 1'b1;
        else if (w_hs) r_ptr_fma <= !w_grant_fma;
    end
`else
    assign w_grant_fma = !bus.alu_valid || bus.fma_valid;
`endif

    assign bus.fma_ready = w_ok && w_grant_fma;
    assign bus.alu_ready = w_ok && !w_grant_fma;
    assign w_hs          = (bus.fma_valid && bus.fma_ready) || (bus.alu_valid && bus.alu_ready);
    assign w_adv         = !bus.stall;

    // The issue stage is the datapath's input register, so it freezes with stall
    // exactly like the tracker; otherwise a stalled op would be lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_issue_valid <= 1'b0;
            r_issue_src   <= SRC_ALU;
            r_issue_req   <= '0;
            r_issue_tag   <= '0;
        end else if (bus.flush) begin
            r_issue_valid <= 1'b0;
        end else if (!bus.stall) begin
            r_issue_valid <= w_hs;
            if (w_hs) begin
                r_issue_src <= w_grant_fma ? SRC_FMA : SRC_ALU;
                r_issue_req <= w_grant_fma ? bus.fma_req : bus.alu_req;
                r_issue_tag <= w_grant_fma ? bus.fma_tag : bus.alu_tag;
            end
        end
    end

    fp_inflight_tracker #(
        .LAT   (LAT),
        .TAG_W (TAG_W)
    ) u_tracker (
        .clk     (clk),
        .reset   (reset),
        .i_adv   (w_adv),
        .i_flush (bus.flush),
        .i_valid (r_issue_valid),
        .i_src   (r_issue_src),
        .i_tag   (r_issue_tag),
        .o_valid (bus.done_valid),
        .o_src   (bus.done_src),
        .o_tag   (bus.done_tag),
        .o_any   (w_trk_any)
    );

    assign bus.issue_valid = r_issue_valid;
    assign bus.issue_req   = r_issue_req;
    assign bus.busy        = r_issue_valid || w_trk_any;

endmodule

// File: doc/fp_addsub_arbiter.md
FP_ADDSUB_ARBITER -- requirements
Module: fp_addsub_arbiter

Interface
REQ-001 SHALL have parameter LAT, default 3: fixed pipeline depth, in cycles, of the shared FP add/sub datapath (legal range 1..8).
REQ-002 SHALL have parameter TAG_W, default 5: width of the requester tags.
REQ-003 SHALL have port clk, input, 1: the single clock.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports fma_valid (input, 1), fma_ready (output, 1), fma_req (input, fp_add_req_t) and fma_tag (input, TAG_W): the fused-multiply accumulate requester.
REQ-006 SHALL have ports alu_valid (input, 1), alu_ready (output, 1), alu_req (input, fp_add_req_t) and alu_tag (input, TAG_W): the plain FADD/FSUB requester.
REQ-007 SHALL have port stall, input, 1: downstream hold, which freezes the datapath and the tracking state.
REQ-008 SHALL have port flush, input, 1: kills all in-flight operations.
REQ-009 SHALL have ports issue_valid (output, 1) and issue_req (output, fp_add_req_t): the operand drive into the add/sub datapath.
REQ-010 SHALL have ports done_valid (output, 1), done_src (output, 1; 1 = FMA, 0 = ALU) and done_tag (output, TAG_W): completion, aligned with the datapath result.
REQ-011 SHALL have port busy, output, 1: high when any operation is in flight.

Function
REQ-012 SHALL grant at most one requester per cycle; a handshake occurs when valid and ready are both high on the same rising edge.
REQ-013 SHALL drive ready only to the granted requester, and only when stall=0 and flush=0; ready SHALL NOT depend on the other requester's data.
REQ-014 SHALL register issue_valid and issue_req, so the datapath sees the operands one cycle after the handshake.
REQ-015 SHALL track each issued operation in a LAT-entry shift register holding {valid, src, tag}; the register SHALL advance only when stall=0.
REQ-016 SHALL assert done_valid, with the matching src and tag, exactly LAT+1 cycles after the handshake cycle when no stall occurs; each stall cycle SHALL add exactly one cycle.
REQ-017 SHALL hold done_valid, done_src and done_tag stable while stall=1.
REQ-018 SHALL, on flush=1, clear every tracking valid bit and issue_valid on the next edge, with no grant that cycle; flush SHALL take priority over stall.
REQ-019 SHALL, when both requesters are valid, grant according to REQ-025/REQ-026; when only one is valid, it SHALL be granted.
REQ-020 SHALL drive busy as the OR of issue_valid and all tracking valid bits.
REQ-021 SHALL pass the request payload (add_sub, operand fields, NaN/zero flags) to issue_req unmodified; it SHALL not decode special values.

Reset
REQ-022 SHALL, on reset=1 at a rising edge, clear issue_valid, all tracking valid bits, done_valid and busy, and set the round-robin pointer to FMA.
REQ-023 SHALL hold fma_ready and alu_ready at 0 during the reset cycle; reset SHALL override flush and stall.
REQ-024 SHALL zero issue_req, done_src and done_tag on reset.

Configuration
REQ-025 SHALL, with FP_ARB_ROUND_ROBIN_EN defined, alternate the grant on conflict using a 1-bit pointer; the pointer SHALL flip to the other requester after each handshake.
REQ-026 SHALL, without FP_ARB_ROUND_ROBIN_EN, use fixed priority FMA > ALU, with no pointer state.

Structure
REQ-027 SHALL take fp_add_req_t {add_sub, num1_sign, num1_exp[7:0], num1_mant[46:0], num2[31:0], num1_is_nan, num1_is_zero} (91 bits) and the SRC_FMA/SRC_ALU constants from the shared FP package.
REQ-028 SHALL implement the tracking shift register as the sub-module fp_inflight_tracker, parameterised by LAT and TAG_W.

Verification
REQ-029 SHALL cover: ALU-only handshake at cycle 10 with tag 3 -> issue_valid at cycle 11 and done_valid/src=0/tag=3 at cycle 14 (LAT=3).
REQ-030 SHALL cover: both requesters valid for 4 cycles with fixed priority -> 4 FMA grants and alu_ready=0 throughout; with FP_ARB_ROUND_ROBIN_EN -> grants F,A,F,A.
REQ-031 SHALL cover: FMA handshake at cycle 5, then stall for cycles 6-7 -> done at cycle 11, with done fields held steady during the stall.
REQ-032 SHALL cover: 3 back-to-back issues, then flush at the next cycle -> no done_valid ever, busy=0 one cycle after the flush, and no ready during the flush.
REQ-033 SHALL cover: stall and flush asserted together -> flush behaviour applies.
REQ-034 SHALL cover: reset mid-stream with 2 operations in flight -> all outputs at reset values next cycle, and no stale done afterwards.
